// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial byte assembler.
package serial_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_SHIFT  = 2'b01;
  localparam state_t ST_PARITY = 2'b10;
  localparam state_t ST_DONE   = 2'b11;

endpackage

// File: rtl/serial_byte_assembler_shift_reg_8.sv
// 8-bit register loaded one bit at a time by index, with synchronous clear.
module shift_reg_8 (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            en,
  input  logic [serial_pkg::CNT_W-1:0]    idx,
  input  logic                            bit_in,
  output logic [serial_pkg::BYTE_W-1:0]   data
);

  logic [serial_pkg::BYTE_W-1:0] data_q;
  logic [serial_pkg::BYTE_W-1:0] data_d;

  // Clear wins over a load arriving on the same edge.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d[idx] = bit_in;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/serial_byte_assembler.sv
// Assembles an LSB-first serial stream into a byte, optionally checks even parity.
module serial_byte_assembler #(
  parameter int PARITY_EN = 0,
  parameter int BYTE_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              serial_in,
  input  logic              serial_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              busy,
  output logic              parity_error
);

  import serial_pkg::CNT_W;
  import serial_pkg::state_t;
  import serial_pkg::ST_IDLE;
  import serial_pkg::ST_SHIFT;
  import serial_pkg::ST_PARITY;
  import serial_pkg::ST_DONE;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               perr_q, perr_d;
  logic               sr_clr, sr_en;
  logic [BYTE_W-1:0]  sr_data;
  logic [BYTE_W-1:0]  merged;

  shift_reg_8 u_shift_reg (
    .clk    (clk),
    .clr    (sr_clr | ~reset_n),
    .en     (sr_en & reset_n),
    .idx    (cnt_q),
    .bit_in (serial_in),
    .data   (sr_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    perr_d  = perr_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    // The final data bit lands in the shift register on the same edge that
    // loads byte_out, so the holding register takes the merged view.
    merged         = sr_data;
    merged[cnt_q]  = serial_in;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (serial_valid) begin
          sr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTE_W - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_DONE;
              byte_d  = merged;
              perr_d  = 1'b0;
            end
          end
        end
      end
      ST_PARITY: begin
        if (serial_valid) begin
          state_d = ST_DONE;
          byte_d  = sr_data;
          perr_d  = serial_in ^ (^sr_data);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
    end
  end

  assign byte_out     = byte_q;
  assign byte_valid   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign parity_error = perr_q;

endmodule
